program_counter_unit: RTL and testbench
=======================================

Name: program_counter_unit

Overview:
- Parametrised successor of the ECO32 program counter register.
- Holds the fetch PC with a configurable width and configurable reset/vector addresses.
- Adds three things the old register lacks: an exception-PC capture register, an N-deep history of previously executed PCs (for exception return and debug trace), and explicit hold codes.
- Sits in the CPU between the control FSM (source select, write enable) and the fetch/ALU datapath.

Parameters:
ADDR_WIDTH, 32, PC width in bits (>=8); word offsets are ADDR_WIDTH-2 bits
RESET_VECTOR, 32'hE0000000, PC value after reset (truncated to ADDR_WIDTH)
VECTOR_BASE_0, 32'hE0000000, handler base when vectorBit=0
VECTOR_BASE_1, 32'hC0000000, handler base when vectorBit=1
HISTORY_DEPTH, 2, number of previous-PC stages (1..8)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous reset, active-low (0 = reset, sampled on rising clock edge)
writeEnable  in  1  1 = update PC this cycle
writeDataSource  in  3  next-PC source code (see Behaviour)
extendedImmediateValue  in  ADDR_WIDTH-2  signed word offset, immediate branch
extendedJumpOffset  in  ADDR_WIDTH-2  signed word offset, jump
explicitValue  in  ADDR_WIDTH  absolute target (jr/rfx)
vectorBit  in  1  selects VECTOR_BASE_0/1
programCounter  out  ADDR_WIDTH  current PC
exceptionPc  out  ADDR_WIDTH  PC captured at last exception/TLB-miss entry
historyPc  out  ADDR_WIDTH*HISTORY_DEPTH  stage k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]; stage 0 newest
historyCount  out  4  number of valid history stages, saturates at HISTORY_DEPTH

Behaviour:
- Reset (reset=0 at a rising edge) sets:
  - programCounter = RESET_VECTOR
  - exceptionPc = 0
  - all history stages = 0
  - historyCount = 0
- Reset has priority over writeEnable; reset mid-sequence discards all history.
- writeEnable=0: all registers hold, whatever writeDataSource is.
- writeEnable=1: next PC is chosen by writeDataSource (all arithmetic modulo 2^ADDR_WIDTH, wrap silently):
  - 0 INCREMENT: PC+4
  - 1 ADD_IMMEDIATE: PC + (sign-extended extendedImmediateValue << 2)
  - 2 ADD_OFFSET: PC + (sign-extended extendedJumpOffset << 2)
  - 3 EXPLICIT: explicitValue
  - 4 EXCEPTION: base+4
  - 5 USER_TLB_MISS: base+8
  - 6, 7 HOLD: PC unchanged; history also unchanged (treated as writeEnable=0)
- "base" above is VECTOR_BASE_1 if vectorBit=1, else VECTOR_BASE_0.
- Latency: new PC is visible one cycle after the enabling edge; outputs are registered, with no combinational path from inputs to outputs.
- History, on every effective write (codes 0..5):
  - stage 0 <= old PC; stage k <= stage k-1
  - historyCount <= min(historyCount+1, HISTORY_DEPTH)
  - when full, the oldest stage drops off.
- exceptionPc, on codes 4/5: loads the old PC (the PC of the interrupted instruction) in the same edge as the PC update; otherwise holds.
- Back-to-back exceptions: each one overwrites exceptionPc with its own old PC.
- Wrap-around examples:
  - PC = all-ones-minus-3, INCREMENT -> 0
  - negative offsets subtract correctly.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN
- Defined:
  - extra output misaligned (1 bit, reset 0)
  - on EXPLICIT, misaligned <= |explicitValue[1:0]; the loaded PC has bits [1:0] forced to 0
  - any other effective write clears misaligned.
- Undefined:
  - no misaligned port
  - explicitValue is loaded verbatim, low bits included.

Decomposition:
- Shared package/include, program_counter_constants: PC_SOURCE_WIDTH=3 and the eight PC_SOURCE_* codes (INCREMENT, ADD_IMMEDIATE, ADD_OFFSET, EXPLICIT, EXCEPTION, USER_TLB_MISS, HOLD0, HOLD1).
- One natural sub-module, program_counter_history: the parametrised shift register plus saturating counter, with inputs shiftEnable and shiftData.

Test Plan:
- Reset held low 2 cycles, then released -> programCounter=E0000000, historyCount=0, exceptionPc=0.
- Force PC=9ABC9ABC:
  - INCREMENT -> 9ABC9AC0
  - writeEnable=0 -> stays 9ABC9ABC
  - code 6 with writeEnable=1 -> stays 9ABC9ABC
  - historyCount unchanged by the hold cases.
- Force PC=9ABC9ABC, imm=100 -> 9ABC9EBC; offset=200 -> 9ABCA2BC; imm=3FFFFFFF (-1) -> 9ABC9AB8; PC=FFFFFFFC with INCREMENT -> 00000000.
- PC=9ABC9ABC with EXCEPTION:
  - vectorBit=0 -> PC=E0000004, exceptionPc=9ABC9ABC
  - vectorBit=1 -> C0000004
  - USER_TLB_MISS, vectorBit=1 -> C0000008, exceptionPc updated.
- HISTORY_DEPTH=2: three INCREMENTs from 1000:
  - historyPc stage0=1008, stage1=1004
  - historyCount=2 (saturated)
  - reset low mid-stream -> all cleared.
- PC_ALIGN_CHECK_EN, EXPLICIT with 12345679 -> PC=12345678, misaligned=1; next INCREMENT -> misaligned=0.

Source files
------------

// File: rtl/program_counter_constants.sv
// rtl/program_counter_constants.sv - shared next-PC source codes for the program counter unit
package program_counter_constants;

    localparam int PC_SOURCE_WIDTH = 3;

    typedef enum logic [PC_SOURCE_WIDTH-1:0] {
        PC_SOURCE_INCREMENT     = 3'd0,
        PC_SOURCE_ADD_IMMEDIATE = 3'd1,
        PC_SOURCE_ADD_OFFSET    = 3'd2,
        PC_SOURCE_EXPLICIT      = 3'd3,
        PC_SOURCE_EXCEPTION     = 3'd4,
        PC_SOURCE_USER_TLB_MISS = 3'd5,
        PC_SOURCE_HOLD0         = 3'd6,
        PC_SOURCE_HOLD1         = 3'd7
    } pcSource_t;

    function automatic logic isHoldSource(input logic [PC_SOURCE_WIDTH-1:0] source);
        return (source == PC_SOURCE_HOLD0) || (source == PC_SOURCE_HOLD1);
    endfunction

    // Both exception-style entries capture the interrupted PC.
    function automatic logic isVectorEntry(input logic [PC_SOURCE_WIDTH-1:0] source);
        return (source == PC_SOURCE_EXCEPTION) || (source == PC_SOURCE_USER_TLB_MISS);
    endfunction

endpackage

// File: rtl/program_counter_history.sv
// rtl/program_counter_history.sv - shift register of previously executed PCs with saturating fill count
module program_counter_history #(
    parameter int ADDR_WIDTH    = 32,
    parameter int HISTORY_DEPTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               shiftEnable,
    input  logic [ADDR_WIDTH-1:0]              shiftData,
    output logic [ADDR_WIDTH*HISTORY_DEPTH-1:0] historyPc,
    output logic [3:0]                         historyCount
);

    localparam logic [3:0] FULL_COUNT = 4'(HISTORY_DEPTH);

    logic [ADDR_WIDTH-1:0] stages [HISTORY_DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < HISTORY_DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else if (shiftEnable) begin
            // Oldest stage falls off the end once the register is full.
            stages[0] <= shiftData;
            for (int k = 1; k < HISTORY_DEPTH; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            historyCount <= '0;
        end else if (shiftEnable && (historyCount != FULL_COUNT)) begin
            historyCount <= historyCount + 4'd1;
        end
    end

    for (genvar g = 0; g < HISTORY_DEPTH; g++) begin : gPack
        assign historyPc[g*ADDR_WIDTH +: ADDR_WIDTH] = stages[g];
    end

endmodule

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - fetch PC register with exception capture and PC history; option PC_ALIGN_CHECK_EN
module program_counter_unit
    import program_counter_constants::*;
#(
    parameter int          ADDR_WIDTH    = 32,
    parameter logic [31:0] RESET_VECTOR  = 32'hE0000000,
    parameter logic [31:0] VECTOR_BASE_0 = 32'hE0000000,
    parameter logic [31:0] VECTOR_BASE_1 = 32'hC0000000,
    parameter int          HISTORY_DEPTH = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                writeEnable,
    input  logic [PC_SOURCE_WIDTH-1:0]          writeDataSource,
    input  logic [ADDR_WIDTH-3:0]               extendedImmediateValue,
    input  logic [ADDR_WIDTH-3:0]               extendedJumpOffset,
    input  logic [ADDR_WIDTH-1:0]               explicitValue,
    input  logic                                vectorBit,
    output logic [ADDR_WIDTH-1:0]               programCounter,
    output logic [ADDR_WIDTH-1:0]               exceptionPc,
    output logic [ADDR_WIDTH*HISTORY_DEPTH-1:0] historyPc,
    output logic [3:0]                          historyCount
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                                misaligned
`endif
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);
    localparam logic [ADDR_WIDTH-1:0] BASE_0   = ADDR_WIDTH'(VECTOR_BASE_0);
    localparam logic [ADDR_WIDTH-1:0] BASE_1   = ADDR_WIDTH'(VECTOR_BASE_1);

    logic                  effectiveWrite;
    logic                  vectorEntry;
    logic [ADDR_WIDTH-1:0] vectorBase;
    logic [ADDR_WIDTH-1:0] explicitTarget;
    logic [ADDR_WIDTH-1:0] nextPc;

    assign effectiveWrite = writeEnable && !isHoldSource(writeDataSource);
    assign vectorEntry    = isVectorEntry(writeDataSource);
    assign vectorBase     = vectorBit ? BASE_1 : BASE_0;

`ifdef PC_ALIGN_CHECK_EN
    assign explicitTarget = {explicitValue[ADDR_WIDTH-1:2], 2'b00};
`else
    assign explicitTarget = explicitValue;
`endif

    // Word offsets shifted left by two are exactly the offset with two zero bits appended.
    always_comb begin
        nextPc = programCounter;
        case (writeDataSource)
            PC_SOURCE_INCREMENT:     nextPc = programCounter + ADDR_WIDTH'(4);
            PC_SOURCE_ADD_IMMEDIATE: nextPc = programCounter + {extendedImmediateValue, 2'b00};
            PC_SOURCE_ADD_OFFSET:    nextPc = programCounter + {extendedJumpOffset, 2'b00};
            PC_SOURCE_EXPLICIT:      nextPc = explicitTarget;
            PC_SOURCE_EXCEPTION:     nextPc = vectorBase + ADDR_WIDTH'(4);
            PC_SOURCE_USER_TLB_MISS: nextPc = vectorBase + ADDR_WIDTH'(8);
            default:                 nextPc = programCounter;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            programCounter <= RESET_PC;
        end else if (effectiveWrite) begin
            programCounter <= nextPc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            exceptionPc <= '0;
        end else if (effectiveWrite && vectorEntry) begin
            exceptionPc <= programCounter;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            misaligned <= 1'b0;
        end else if (effectiveWrite) begin
            misaligned <= (writeDataSource == PC_SOURCE_EXPLICIT) && (|explicitValue[1:0]);
        end
    end
`endif

    program_counter_history #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .HISTORY_DEPTH (HISTORY_DEPTH)
    ) history (
        .clock        (clock),
        .reset        (reset),
        .shiftEnable  (effectiveWrite),
        .shiftData    (programCounter),
        .historyPc    (historyPc),
        .historyCount (historyCount)
    );

endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - randomized and directed check of program_counter_unit against a behavioural model
module tb_program_counter_unit;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        writeEnable = 1'b0;
    logic [2:0]  writeDataSource = 3'd0;
    logic [29:0] extendedImmediateValue = '0;
    logic [29:0] extendedJumpOffset = '0;
    logic [31:0] explicitValue = '0;
    logic        vectorBit = 1'b0;
    logic [31:0] programCounter;
    logic [31:0] exceptionPc;
    logic [32*DEPTH-1:0] historyPc;
    logic [3:0]  historyCount;
`ifdef PC_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    program_counter_unit #(
        .ADDR_WIDTH    (32),
        .RESET_VECTOR  (32'hE0000000),
        .VECTOR_BASE_0 (32'hE0000000),
        .VECTOR_BASE_1 (32'hC0000000),
        .HISTORY_DEPTH (DEPTH)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .writeEnable            (writeEnable),
        .writeDataSource        (writeDataSource),
        .extendedImmediateValue (extendedImmediateValue),
        .extendedJumpOffset     (extendedJumpOffset),
        .explicitValue          (explicitValue),
        .vectorBit              (vectorBit),
        .programCounter         (programCounter),
        .exceptionPc            (exceptionPc),
        .historyPc              (historyPc),
        .historyCount           (historyCount)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned             (misaligned)
`endif
    );

    always #5 clock = ~clock;

    int assertCount = 0;
    int failCount = 0;

    logic [31:0] mPc = 32'hE0000000;
    logic [31:0] mExc = 32'h0;
    logic [31:0] mHist [$];
    logic        mMis = 1'b0;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic longint wordOffset(input logic [29:0] raw);
        longint v = longint'(raw);
        if (v >= 64'sd536870912) v = v - 64'sd1073741824;
        return v * 4;
    endfunction

    task automatic modelUpdate(input logic rst, input logic we, input logic [2:0] src,
                               input logic [29:0] imm, input logic [29:0] off,
                               input logic [31:0] expl, input logic vb);
        logic [31:0] base;
        logic [31:0] newPc;
        base = vb ? 32'hC0000000 : 32'hE0000000;
        if (!rst) begin
            mPc = 32'hE0000000;
            mExc = 0;
            mHist.delete();
            mMis = 0;
        end else if (we && src < 3'd6) begin
            case (src)
                3'd0: newPc = 32'(longint'(mPc) + 4);
                3'd1: newPc = 32'(longint'(mPc) + wordOffset(imm));
                3'd2: newPc = 32'(longint'(mPc) + wordOffset(off));
`ifdef PC_ALIGN_CHECK_EN
                3'd3: newPc = expl & 32'hFFFFFFFC;
`else
                3'd3: newPc = expl;
`endif
                3'd4: newPc = base + 4;
                default: newPc = base + 8;
            endcase
            mMis = (src == 3'd3) && (expl % 4 != 0);
            if (src >= 3'd4) mExc = mPc;
            mHist.push_front(mPc);
            if (mHist.size() > DEPTH) void'(mHist.pop_back());
            mPc = newPc;
        end
    endtask

    task automatic doCycle(input logic rst, input logic we, input logic [2:0] src,
                           input logic [29:0] imm, input logic [29:0] off,
                           input logic [31:0] expl, input logic vb);
        reset = rst;
        writeEnable = we;
        writeDataSource = src;
        extendedImmediateValue = imm;
        extendedJumpOffset = off;
        explicitValue = expl;
        vectorBit = vb;
        @(posedge clock);
        #1;
        modelUpdate(rst, we, src, imm, off, expl, vb);
        checkValue("pc", programCounter, mPc);
        checkValue("exceptionPc", exceptionPc, mExc);
        checkValue("historyCount", {28'd0, historyCount}, 32'(mHist.size()));
        for (int k = 0; k < DEPTH; k++) begin
            checkValue($sformatf("history%0d", k), historyPc[k*32 +: 32],
                       (k < mHist.size()) ? mHist[k] : 32'h0);
        end
`ifdef PC_ALIGN_CHECK_EN
        checkValue("misaligned", {31'd0, misaligned}, {31'd0, mMis});
`endif
    endtask

    task automatic op(input logic [2:0] src, input logic [31:0] expl);
        doCycle(1'b1, 1'b1, src, 30'd0, 30'd0, expl, 1'b0);
    endtask

    logic [3:0] savedCount;

    initial begin
        doCycle(1'b0, 1'b1, 3'd0, 30'd0, 30'd0, 32'h0, 1'b0);
        doCycle(1'b0, 1'b1, 3'd0, 30'd0, 30'd0, 32'h0, 1'b0);
        checkValue("resetPc", programCounter, 32'hE0000000);
        checkValue("resetCount", {28'd0, historyCount}, 32'd0);
        checkValue("resetExc", exceptionPc, 32'd0);

        op(3'd3, 32'h9ABC9ABC);
        op(3'd0, 32'h0);
        checkValue("increment", programCounter, 32'h9ABC9AC0);
        op(3'd3, 32'h9ABC9ABC);
        savedCount = historyCount;
        doCycle(1'b1, 1'b0, 3'd0, 30'd0, 30'd0, 32'h0, 1'b0);
        checkValue("weLowHold", programCounter, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd6, 30'd5, 30'd5, 32'h0, 1'b1);
        checkValue("code6Hold", programCounter, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd7, 30'd5, 30'd5, 32'h0, 1'b1);
        checkValue("holdCount", {28'd0, historyCount}, {28'd0, savedCount});

        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd1, 30'h100, 30'd0, 32'h0, 1'b0);
        checkValue("addImm", programCounter, 32'h9ABC9EBC);
        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd2, 30'd0, 30'h200, 32'h0, 1'b0);
        checkValue("addOffset", programCounter, 32'h9ABCA2BC);
        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd1, 30'h3FFFFFFF, 30'd0, 32'h0, 1'b0);
        checkValue("addImmNeg", programCounter, 32'h9ABC9AB8);
        op(3'd3, 32'hFFFFFFFC);
        op(3'd0, 32'h0);
        checkValue("wrap", programCounter, 32'h00000000);

        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd4, 30'd0, 30'd0, 32'h0, 1'b0);
        checkValue("exc0Pc", programCounter, 32'hE0000004);
        checkValue("exc0Capture", exceptionPc, 32'h9ABC9ABC);
        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd4, 30'd0, 30'd0, 32'h0, 1'b1);
        checkValue("exc1Pc", programCounter, 32'hC0000004);
        op(3'd3, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd5, 30'd0, 30'd0, 32'h0, 1'b1);
        checkValue("tlbPc", programCounter, 32'hC0000008);
        checkValue("tlbCapture", exceptionPc, 32'h9ABC9ABC);
        doCycle(1'b1, 1'b1, 3'd4, 30'd0, 30'd0, 32'h0, 1'b0);
        checkValue("backToBack", exceptionPc, 32'hC0000008);

        doCycle(1'b0, 1'b1, 3'd0, 30'd0, 30'd0, 32'h0, 1'b0);
        op(3'd3, 32'h1000);
        op(3'd0, 32'h0);
        op(3'd0, 32'h0);
        op(3'd0, 32'h0);
        checkValue("histStage0", historyPc[31:0], 32'h1008);
        checkValue("histStage1", historyPc[63:32], 32'h1004);
        checkValue("histFull", {28'd0, historyCount}, 32'd2);
        doCycle(1'b0, 1'b1, 3'd0, 30'd0, 30'd0, 32'h0, 1'b0);
        checkValue("histCleared", historyPc[63:32] | historyPc[31:0], 32'h0);
        checkValue("countCleared", {28'd0, historyCount}, 32'd0);

`ifdef PC_ALIGN_CHECK_EN
        op(3'd3, 32'h12345679);
        checkValue("alignPc", programCounter, 32'h12345678);
        checkValue("alignFlag", {31'd0, misaligned}, 32'd1);
        op(3'd0, 32'h0);
        checkValue("alignClear", {31'd0, misaligned}, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            doCycle($urandom_range(0, 39) != 0, $urandom_range(0, 4) != 0,
                    3'($urandom_range(0, 7)), 30'($urandom), 30'($urandom),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
